// File: rtl/cic_integ_decim.sv
// Integrator and decimator half of a 3-stage CIC decimation filter.
// Three full-rate integrators feed a divide-by-R strobe. The output is
// registered once and drives the downstream comb (dout -> din, dout_valid -> en).
// All adds wrap modulo 2^DOUT_W; the comb's modular subtraction undoes the wrap.
module cic_integ_decim #(
  parameter int DIN_W  = 14,
  parameter int DOUT_W = 21,
  parameter int R      = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic signed [DIN_W-1:0]  din,
  input  logic                     din_valid,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_valid
);

  localparam int CNT_W = (R > 2) ? $clog2(R) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

  // Sign-extend an input sample to the integrator width.
  function automatic logic signed [DOUT_W-1:0] sext(input logic signed [DIN_W-1:0] x);
    return {{(DOUT_W-DIN_W){x[DIN_W-1]}}, x};
  endfunction

  logic signed [DOUT_W-1:0] i1_p0, i2_p0, i3_p0;
  logic        [CNT_W-1:0]  cnt_p0;
  logic                     decim_p0;
  logic signed [DOUT_W-1:0] dout_p1;
  logic                     vld_p1;

  assign decim_p0 = din_valid && (cnt_p0 == CNT_LAST);

  // Stage p0: integrator cascade and decimation counter; every register updates
  // from pre-update values, and only on accepted samples. clr beats din_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i1_p0  <= '0;
      i2_p0  <= '0;
      i3_p0  <= '0;
      cnt_p0 <= '0;
    end else if (clr) begin
      i1_p0  <= '0;
      i2_p0  <= '0;
      i3_p0  <= '0;
      cnt_p0 <= '0;
    end else if (din_valid) begin
      i1_p0  <= i1_p0 + sext(din);
      i2_p0  <= i2_p0 + i1_p0;
      i3_p0  <= i3_p0 + i2_p0;
      cnt_p0 <= decim_p0 ? '0 : cnt_p0 + 1'b1;
    end
  end

  // Stage p1: capture the pre-update i3 on the R-th sample; dout holds between strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (clr) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= decim_p0;
      if (decim_p0) begin
        dout_p1 <= i3_p0;
      end
    end
  end

  assign dout       = dout_p1;
  assign dout_valid = vld_p1;

endmodule

// File: tb/tb_cic_integ_decim.sv
// Bench for cic_integ_decim: a sample-level model pushes expected strobes into
// a scoreboard queue as stimulus is driven; a monitor pops and compares them
// every cycle. A comb model on the DUT output checks the DC gain.
module tb_cic_integ_decim;

  localparam int DIN_W  = 14;
  localparam int DOUT_W = 21;
  localparam int R      = 5;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    clr = 1'b0;
  logic signed [DIN_W-1:0] din = '0;
  logic                    din_valid = 1'b0;
  logic [DOUT_W-1:0]       dout;
  logic                    dout_valid;

  cic_integ_decim #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .R(R)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [DOUT_W-1:0] exp_q[$];
  logic [DOUT_W-1:0] got_q[$];
  logic [DOUT_W-1:0] comb_q[$];
  int                strobe_cyc[$];

  logic [DOUT_W-1:0] m_i1 = '0, m_i2 = '0, m_i3 = '0, m_hold = '0;
  int                m_cnt = 0;
  logic [DOUT_W-1:0] c_d0 = '0, c_d1 = '0, c_d2 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DOUT_W-1:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 'x;
  endfunction

  function automatic logic [DOUT_W-1:0] comb_at(input int i);
    return (i < comb_q.size()) ? comb_q[i] : 'x;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < strobe_cyc.size()) ? strobe_cyc[i] : -1000;
  endfunction

  task automatic model_clear();
    m_i1 = '0; m_i2 = '0; m_i3 = '0; m_hold = '0; m_cnt = 0;
  endtask

  // Drive one cycle of stimulus and advance the model.
  task automatic drive(input logic v, input logic signed [DIN_W-1:0] d, input logic c);
    logic [DOUT_W-1:0] sx;
    @(negedge clk);
    din = d; din_valid = v; clr = c;
    sx = DOUT_W'(int'(d));
    if (c) begin
      model_clear();
    end else if (v) begin
      if (m_cnt == R - 1) begin
        exp_q.push_back(m_i3);
        m_hold = m_i3;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_i3 = m_i3 + m_i2;
      m_i2 = m_i2 + m_i1;
      m_i1 = m_i1 + sx;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  // Monitor: per-cycle scoreboard check, strobe log and comb model.
  always @(posedge clk) begin : mon
    logic [DOUT_W-1:0] e, c1, c2, c3;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("strobe", dout_valid, 1);
      check("dout_at_strobe", dout, e);
    end else begin
      check("no_strobe", dout_valid, 0);
      check("dout_hold", dout, m_hold);
    end
    if (!rstn || clr) begin
      c_d0 = '0; c_d1 = '0; c_d2 = '0;
    end else if (dout_valid) begin
      got_q.push_back(dout);
      strobe_cyc.push_back(cyc);
      c1 = dout - c_d0; c_d0 = dout;
      c2 = c1 - c_d1;   c_d1 = c1;
      c3 = c2 - c_d2;   c_d2 = c2;
      comb_q.push_back(c3);
    end
  end

  initial begin
    int b;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_dout", dout, 0);
    check("reset_vld", dout_valid, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Positive impulse
    b = got_q.size();
    drive(1'b1, 14'sd1, 1'b0);
    repeat (14) drive(1'b1, '0, 1'b0);
    idle(3);
    check("imp_count", got_q.size() - b, 3);
    check("imp_0", got_at(b), 3);
    check("imp_1", got_at(b + 1), 28);
    check("imp_2", got_at(b + 2), 78);

    // Negative impulse
    drive(1'b0, '0, 1'b1);
    b = got_q.size();
    drive(1'b1, -14'sd1, 1'b0);
    repeat (9) drive(1'b1, '0, 1'b0);
    idle(3);
    check("neg_0", got_at(b), 21'h1FFFFD);
    check("neg_1", got_at(b + 1), 21'h1FFFE4);

    // Gapped impulse
    drive(1'b0, '0, 1'b1);
    b = got_q.size();
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, (k == 0) ? 14'sd1 : 14'sd0, 1'b0);
      drive(1'b0, '0, 1'b0);
    end
    idle(3);
    check("gap_0", got_at(b), 3);
    check("gap_1", got_at(b + 1), 28);
    check("gap_2", got_at(b + 2), 78);
    check("gap_space_01", cyc_at(b + 1) - cyc_at(b), 10);
    check("gap_space_12", cyc_at(b + 2) - cyc_at(b + 1), 10);

    // DC 100 through comb
    drive(1'b0, '0, 1'b1);
    b = comb_q.size();
    repeat (40) drive(1'b1, 14'sd100, 1'b0);
    idle(3);
    check("dc_count", comb_q.size() - b, 8);
    for (int i = b + 4; i < comb_q.size(); i++) check("comb_dc100", comb_at(i), 12500);

    // Full-scale DC with integrator wrap
    drive(1'b0, '0, 1'b1);
    b = comb_q.size();
    repeat (10000) drive(1'b1, 14'sd8191, 1'b0);
    idle(3);
    check("fs_count", comb_q.size() - b, 2000);
    for (int i = b + 4; i < comb_q.size(); i++) check("comb_fullscale", comb_at(i), 1023875);

    // clr with coincident din_valid at cnt=3
    drive(1'b0, '0, 1'b1);
    repeat (3) drive(1'b1, 14'sd7, 1'b0);
    drive(1'b1, 14'sd7, 1'b1);
    b = got_q.size();
    drive(1'b1, 14'sd1, 1'b0);
    repeat (4) drive(1'b1, '0, 1'b0);
    idle(2);
    check("clr_count", got_q.size() - b, 1);
    check("clr_fresh", got_at(b), 3);

    // Asynchronous reset mid-block
    repeat (7) drive(1'b1, 14'sd7, 1'b0);
    idle(1);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    model_clear();
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_vld", dout_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    b = got_q.size();
    drive(1'b1, 14'sd1, 1'b0);
    repeat (4) drive(1'b1, '0, 1'b0);
    idle(2);
    check("rst_count", got_q.size() - b, 1);
    check("rst_fresh", got_at(b), 3);

    idle(2);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
